// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: button debounce plus start/stop/lap/clear sequencer
// for the three-digit BCD stopwatch.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | stopped and cleared, go=0
// RUN   | counting, display live, go=1
// LAP   | counting, display frozen on snapshot, hold=1
// PAUSE | stopped, value kept, go=0
module stop_watch_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] btn_n,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic       go,
  output logic       clr,
  output logic       hold,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] LAP   = 2'b10;
  localparam logic [1:0] PAUSE = 2'b11;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           acc_q, acc_d, acc_dly_q;
  logic [1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [1:0]           press_q;
  logic [1:0]           state_q, state_d;
  logic                 clr_q, clr_d;
  logic [11:0]          lap_q, lap_d;
  logic                 ss_ev, cl_ev;

  // Two-flop synchronizer on the inverted (active-high) buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= ~btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count while the synchronized level disagrees with the accepted one.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        acc_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Accepted levels, counters and the registered rising-edge press pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= 2'b00;
      acc_dly_q <= 2'b00;
      cnt_q     <= '0;
      press_q   <= 2'b00;
    end else begin
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      cnt_q     <= cnt_d;
      press_q   <= acc_q & ~acc_dly_q;
    end
  end

  // Start/stop wins over lap/clear when both arrive in the same cycle.
  assign ss_ev = press_q[1];
  assign cl_ev = press_q[0] & ~press_q[1];

  // Next-state, clear pulse and lap capture decisions.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    lap_d   = lap_q;
    case (state_q)
      IDLE: begin
        if (ss_ev)      state_d = RUN;
        else if (cl_ev) clr_d   = 1'b1;
      end
      RUN: begin
        if (ss_ev) begin
          state_d = PAUSE;
        end else if (cl_ev) begin
          state_d = LAP;
          lap_d   = {d2, d1, d0};
        end
      end
      LAP: begin
        if (ss_ev)      state_d = PAUSE;
        else if (cl_ev) state_d = RUN;
      end
      PAUSE: begin
        if (ss_ev) begin
          state_d = RUN;
        end else if (cl_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, clear pulse and lap snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      lap_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end

  assign go    = (state_q == RUN) || (state_q == LAP);
  assign hold  = (state_q == LAP);
  assign state = state_q;
  assign clr   = clr_q;

  // Frozen snapshot only while in LAP; otherwise the live digits.
  always_comb begin
    if (state_q == LAP) {disp2, disp1, disp0} = lap_q;
    else                {disp2, disp1, disp0} = {d2, d1, d0};
  end

endmodule

// File: tb/tb_stop_watch_ctrl.sv
module tb_stop_watch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] btn_n = 2'b11;
  logic [3:0] d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic       go, clr, hold;
  logic [3:0] disp2, disp1, disp0;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0;
  bit mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;

  typedef struct packed {
    logic [1:0] st;
    logic       go;
    logic       hold;
  } exp_t;
  exp_t exp_q[$];

  stop_watch_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n),
    .d2(d2), .d1(d1), .d0(d0),
    .go(go), .clr(clr), .hold(hold),
    .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .state(state)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every state change pops one expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (clr) begin
        clr_cnt++;
        total++;
        if (go !== 1'b0) begin
          bad++;
          $display("FAIL clr_with_go: go=%b required 0", go);
        end
      end
      if (state !== prev_state) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_state: state=%b from %b, none expected", state, prev_state);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({state, go, hold} !== {e.st, e.go, e.hold}) begin
            bad++;
            $display("FAIL state_change: state/go/hold=%b/%b/%b required %b/%b/%b",
                     state, go, hold, e.st, e.go, e.hold);
          end
        end
        prev_state = state;
      end
    end
  end

  task automatic push_exp(input logic [1:0] st, input logic g, input logic h);
    exp_t e;
    e.st = st; e.go = g; e.hold = h;
    exp_q.push_back(e);
  endtask

  task automatic press(input int idx, input int n);
    btn_n[idx] = 1'b0;
    repeat (n) @(negedge clk);
    btn_n[idx] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected transitions pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({state, go, clr, hold} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_state: state/go/clr/hold=%b/%b/%b/%b required 00/0/0/0", state, go, clr, hold);
    end
    reset_n = 1'b1;
    prev_state = state;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (state !== 2'b00) begin
      bad++;
      $display("FAIL reset_quiet: state=%b required 00", state);
    end
  endtask

  task automatic test_debounce;
    btn_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    btn_n[1] = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if (state !== 2'b00) begin
      bad++;
      $display("FAIL glitch: state=%b required 00", state);
    end
    push_exp(2'b01, 1'b1, 1'b0);
    btn_n[1] = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (go !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: go=%b at cycle 7 required 0", go);
    end
    @(negedge clk);
    total++;
    if (go !== 1'b1 || state !== 2'b01) begin
      bad++;
      $display("FAIL latency: go=%b state=%b at cycle 8 required 1/01", go, state);
    end
    btn_n[1] = 1'b1;
    repeat (15) @(negedge clk);
    wait_drain("debounce");
  endtask

  task automatic test_run_pause_clear;
    int c0;
    bit seen;
    push_exp(2'b11, 1'b0, 1'b0);
    press(1, 6);
    wait_drain("pause");
    c0 = clr_cnt;
    seen = 1'b0;
    push_exp(2'b00, 1'b0, 1'b0);
    btn_n[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state === 2'b00) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || clr !== 1'b1 || go !== 1'b0) begin
      bad++;
      $display("FAIL clr_on_idle: seen=%b clr=%b go=%b required 1/1/0", seen, clr, go);
    end
    @(negedge clk);
    total++;
    if (clr !== 1'b0) begin
      bad++;
      $display("FAIL clr_width: clr=%b one cycle later required 0", clr);
    end
    btn_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    wait_drain("clear");
    press(0, 6);
    press(0, 6);
    total++;
    if (clr_cnt - c0 != 3 || state !== 2'b00) begin
      bad++;
      $display("FAIL idle_clr_b2b: pulses=%0d state=%b required 3/00", clr_cnt - c0, state);
    end
  endtask

  task automatic test_lap;
    push_exp(2'b01, 1'b1, 1'b0);
    press(1, 6);
    wait_drain("lap_run");
    d2 = 4'd3; d1 = 4'd4; d0 = 4'd5;
    push_exp(2'b10, 1'b1, 1'b1);
    press(0, 6);
    wait_drain("lap_enter");
    d0 = 4'd9;
    @(negedge clk);
    total++;
    if ({disp2, disp1, disp0} !== 12'h345 || go !== 1'b1 || hold !== 1'b1) begin
      bad++;
      $display("FAIL lap_frozen: disp=%h go=%b hold=%b required 345/1/1", {disp2, disp1, disp0}, go, hold);
    end
    push_exp(2'b01, 1'b1, 1'b0);
    press(0, 6);
    wait_drain("lap_exit");
    d0 = 4'd7;
    #1;
    total++;
    if ({disp2, disp1, disp0} !== 12'h347 || hold !== 1'b0) begin
      bad++;
      $display("FAIL lap_live: disp=%h hold=%b required 347/0", {disp2, disp1, disp0}, hold);
    end
    push_exp(2'b10, 1'b1, 1'b1);
    press(0, 6);
    wait_drain("lap_again");
    d1 = 4'd8;
    push_exp(2'b11, 1'b0, 1'b0);
    press(1, 6);
    wait_drain("lap_pause");
    total++;
    if ({disp2, disp1, disp0} !== 12'h387 || hold !== 1'b0) begin
      bad++;
      $display("FAIL lap_to_pause: disp=%h hold=%b required 387/0", {disp2, disp1, disp0}, hold);
    end
    push_exp(2'b01, 1'b1, 1'b0);
    press(1, 6);
    wait_drain("resume");
  endtask

  task automatic test_simultaneous;
    int c0;
    c0 = clr_cnt;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    push_exp(2'b11, 1'b0, 1'b0);
    btn_n = 2'b00;
    repeat (6) @(negedge clk);
    btn_n = 2'b11;
    repeat (15) @(negedge clk);
    wait_drain("simul");
    total++;
    if (state !== 2'b11 || hold !== 1'b0 || clr_cnt != c0 || {disp2, disp1, disp0} !== 12'h123) begin
      bad++;
      $display("FAIL simultaneous: state=%b hold=%b clr_pulses=%0d disp=%h required 11/0/0/123",
               state, hold, clr_cnt - c0, {disp2, disp1, disp0});
    end
  endtask

  task automatic test_bounce;
    int c0;
    c0 = clr_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      btn_n[0] = 1'b1;
      repeat (2) @(negedge clk);
    end
    total++;
    if (state !== 2'b11) begin
      bad++;
      $display("FAIL bounce_no_event: state=%b required 11", state);
    end
    push_exp(2'b00, 1'b0, 1'b0);
    btn_n[0] = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (state !== 2'b11) begin
      bad++;
      $display("FAIL bounce_early: state=%b required 11", state);
    end
    @(negedge clk);
    total++;
    if (state !== 2'b00) begin
      bad++;
      $display("FAIL bounce_event: state=%b required 00", state);
    end
    repeat (20) @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    wait_drain("bounce");
    total++;
    if (clr_cnt - c0 != 1) begin
      bad++;
      $display("FAIL bounce_clr: pulses=%0d required 1", clr_cnt - c0);
    end
  endtask

  task automatic test_reset_mid;
    push_exp(2'b01, 1'b1, 1'b0);
    press(1, 6);
    wait_drain("mid_run");
    push_exp(2'b10, 1'b1, 1'b1);
    press(0, 6);
    wait_drain("mid_lap");
    btn_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(2'b00, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({state, go, clr, hold} !== 5'b00000) begin
      bad++;
      $display("FAIL async_reset: state/go/clr/hold=%b/%b/%b/%b required 00/0/0/0", state, go, clr, hold);
    end
    repeat (3) @(negedge clk);
    push_exp(2'b01, 1'b1, 1'b0);
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    total++;
    if (state !== 2'b00) begin
      bad++;
      $display("FAIL held_early: state=%b required 00", state);
    end
    @(negedge clk);
    total++;
    if (state !== 2'b01 || go !== 1'b1) begin
      bad++;
      $display("FAIL held_through_reset: state=%b go=%b required 01/1", state, go);
    end
    repeat (20) @(negedge clk);
    btn_n[1] = 1'b1;
    repeat (15) @(negedge clk);
    wait_drain("held");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_run_pause_clear();
    test_lap();
    test_simultaneous();
    test_bounce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
